// File: rtl/display_arbiter.sv
// Dashboard display arbiter: rotates between the SPEED and MILE pages,
// pre-empts them with a blinking ALARM page, and drives a saturated,
// registered value to the 7-segment decoder.
module display_arbiter #(
    parameter int unsigned PAGE_CYCLES  = 50000000,
    parameter int unsigned BLINK_CYCLES = 12500000,
    parameter int unsigned SAT_MAX      = 99
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] speed_in,
    input  logic [15:0] mile_in,
    input  logic        alarm_req,
    input  logic [15:0] alarm_code,
    input  logic        key_next,
    output logic [15:0] disp_val,
    output logic        disp_blank,
    output logic [1:0]  page_id,
    output logic        alarm_ack
);

    localparam int unsigned PW = (PAGE_CYCLES  > 1) ? $clog2(PAGE_CYCLES)  : 1;
    localparam int unsigned BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [PW-1:0] PAGE_LAST  = PW'(PAGE_CYCLES - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);
    localparam logic [15:0]   SAT        = 16'(SAT_MAX);

    typedef enum logic [1:0] {
        S_SPEED = 2'd0,
        S_MILE  = 2'd1,
        S_ALARM = 2'd2
    } state_t;

    state_t        state, state_nxt;
    state_t        ret_page, ret_nxt;
    logic          armed, armed_nxt;
    logic [PW-1:0] ptimer, ptimer_nxt;
    logic [BW-1:0] btimer, btimer_nxt;
    logic          blank_nxt;
    logic          ack_nxt;
    logic [15:0]   src;
    logic [15:0]   val_nxt;

    assign page_id = state;

    // Select the value source for the current page and clamp it to SAT_MAX.
    always_comb begin
        src = alarm_code;
        case (state)
            S_SPEED: src = speed_in;
            S_MILE:  src = mile_in;
            default: src = alarm_code;
        endcase
        val_nxt = (src > SAT) ? SAT : src;
    end

    // Next-state logic: page rotation, alarm entry/exit, blink timing, ack pulse.
    always_comb begin
        state_nxt  = state;
        ret_nxt    = ret_page;
        // Any cycle with alarm_req low re-arms; ack below overrides this.
        armed_nxt  = armed | ~alarm_req;
        ptimer_nxt = ptimer;
        btimer_nxt = btimer;
        blank_nxt  = disp_blank;
        ack_nxt    = 1'b0;
        case (state)
            S_SPEED, S_MILE: begin
                blank_nxt = 1'b0;
                if (alarm_req && armed) begin
                    // Alarm takes priority; a coincident key press is dropped.
                    state_nxt  = S_ALARM;
                    ret_nxt    = state;
                    btimer_nxt = '0;
                end else if (key_next || (ptimer == PAGE_LAST)) begin
                    // Key and expiry together still give a single toggle.
                    state_nxt  = (state == S_SPEED) ? S_MILE : S_SPEED;
                    ptimer_nxt = '0;
                end else begin
                    ptimer_nxt = ptimer + 1'b1;
                end
            end
            S_ALARM: begin
                if (key_next) begin
                    ack_nxt    = 1'b1;
                    armed_nxt  = 1'b0;
                    state_nxt  = ret_page;
                    ptimer_nxt = '0;
                    blank_nxt  = 1'b0;
                end else if (!alarm_req) begin
                    state_nxt  = ret_page;
                    ptimer_nxt = '0;
                    blank_nxt  = 1'b0;
                end else if (btimer == BLINK_LAST) begin
                    btimer_nxt = '0;
                    blank_nxt  = ~disp_blank;
                end else begin
                    btimer_nxt = btimer + 1'b1;
                end
            end
            default: begin
                state_nxt = S_SPEED;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_SPEED;
            ret_page   <= S_SPEED;
            armed      <= 1'b1;
            ptimer     <= '0;
            btimer     <= '0;
            disp_val   <= '0;
            disp_blank <= 1'b0;
            alarm_ack  <= 1'b0;
        end else begin
            state      <= state_nxt;
            ret_page   <= ret_nxt;
            armed      <= armed_nxt;
            ptimer     <= ptimer_nxt;
            btimer     <= btimer_nxt;
            disp_val   <= val_nxt;
            disp_blank <= blank_nxt;
            alarm_ack  <= ack_nxt;
        end
    end

endmodule

// File: doc/display_arbiter.md
DISPLAY_ARBITER -- requirements
Module: display_arbiter

Interface
REQ-001 Parameter PAGE_CYCLES, default 50000000, is the auto-rotate period between the SPEED and MILE pages in clk cycles.
REQ-002 Parameter BLINK_CYCLES, default 12500000, is the half-period of the alarm blink in clk cycles.
REQ-003 Parameter SAT_MAX, default 99, is the saturation ceiling applied to disp_val.
REQ-004 clk  in  1  system clock; all state updates on posedge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 speed_in  in  16  current speed value, unsigned.
REQ-007 mile_in  in  16  trip mileage value, unsigned.
REQ-008 alarm_req  in  1  level alarm request.
REQ-009 alarm_code  in  16  value shown while the alarm is active.
REQ-010 key_next  in  1  single-cycle pulse: manual page advance, or alarm acknowledge.
REQ-011 disp_val  out  16  registered value driving the 7-segment decoder.
REQ-012 disp_blank  out  1  1 = display blanked (segments off).
REQ-013 page_id  out  2  current page: 0 = SPEED, 1 = MILE, 2 = ALARM; 3 is never driven.
REQ-014 alarm_ack  out  1  single-cycle pulse on alarm acknowledge.

Function
REQ-015 The FSM SHALL have three states, S_SPEED, S_MILE and S_ALARM; page_id SHALL encode the current state.
REQ-016 Page timer: counts 0..PAGE_CYCLES-1 in S_SPEED and S_MILE; on reaching PAGE_CYCLES-1, the state toggles SPEED<->MILE and the timer clears.
REQ-017 key_next in S_SPEED/S_MILE SHALL toggle the page on the next edge and clear the timer; coincident timer expiry SHALL produce exactly one toggle.
REQ-018 Alarm entry: alarm_req=1 with armed=1 in S_SPEED/S_MILE SHALL move to S_ALARM next edge, save the current page as ret_page, and clear the blink timer; a coincident key_next SHALL be ignored.
REQ-019 In S_ALARM the blink timer counts 0..BLINK_CYCLES-1; disp_blank SHALL toggle at each wrap, starting at 0 on entry.
REQ-020 key_next in S_ALARM SHALL pulse alarm_ack for exactly one cycle, clear armed, return to ret_page, and clear the page timer.
REQ-021 alarm_req deasserting in S_ALARM without key_next SHALL return to ret_page next edge with no alarm_ack; armed stays 1.
REQ-022 If key_next and alarm_req deassertion coincide in S_ALARM, REQ-020 SHALL apply (ack issued).
REQ-023 armed SHALL re-set to 1 on the first cycle alarm_req is sampled 0; while armed=0 a held alarm_req SHALL be ignored.
REQ-024 disp_val SHALL be registered with 1-cycle latency from the source selected by the state held during that cycle: speed_in, mile_in or alarm_code.
REQ-025 disp_val SHALL equal min(source, SAT_MAX) using an unsigned 16-bit compare.
REQ-026 disp_blank SHALL be 0 in S_SPEED and S_MILE, and SHALL be forced to 0 on the cycle S_ALARM is exited.
REQ-027 Timer widths SHALL be at least ceil(log2(max parameter)) bits; no counter may wrap other than as specified.

Reset
REQ-028 While rst=0: state S_SPEED, ret_page SPEED, armed 1, both timers 0, disp_val 0, disp_blank 0, page_id 0, alarm_ack 0.
REQ-029 Reset asserted mid-alarm or mid-page SHALL abort immediately with no alarm_ack pulse; after release, operation resumes from S_SPEED with the timer at 0.

Verification (PAGE_CYCLES=8, BLINK_CYCLES=2, SAT_MAX=99)
REQ-030 Reset release, speed_in=42, mile_in=7, idle -> disp_val=42, page_id=0 for 8 cycles; then page_id=1 and disp_val=7 one cycle later; back to 0 after 8 more.
REQ-031 key_next on timer cycle 3 in SPEED -> page_id=1 next edge; the following toggle occurs 8 cycles later; key_next coincident with expiry -> single toggle.
REQ-032 In MILE, raise alarm_req with alarm_code=13 plus key_next in the same cycle -> page_id=2, disp_val=13, disp_blank sequence 0,0,1,1,0..., no ack; key_next -> alarm_ack one cycle, page_id=1, disp_blank=0.
REQ-033 alarm_req held after ack -> stays in MILE/SPEED rotation; drop alarm_req for 1 cycle, reassert -> page_id=2 again.
REQ-034 speed_in=150 -> disp_val=99; speed_in=16'hFFFF -> 99; speed_in=99 -> 99.
REQ-035 rst pulse low while page_id=2 -> all outputs reset values asynchronously, alarm_ack never pulses, page_id=0 after release.
